// File: rtl/gam_node_scanner.sv
// Read-side scanner: walks one class (or all classes) of GAM node memory and streams each node as a record. Optional GAM_SCAN_SKIP_EMPTY_EN drops nodes whose match count is 0.
// Latency: first rec_valid_o 2 cycles after start_i; 1 record per 2 cycles with rec_ready_i held high.
// Backpressure: HOLD waits indefinitely on rec_ready_i with all record fields frozen and no memory strobes.
module gam_node_scanner #(
    parameter int NUM_CLASSES     = 8,
    parameter int NODES_PER_CLASS = 16,
    parameter int VEC_W           = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             all_classes_i,
    input  logic [31:0]      class_sel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      mem_class_o,
    output logic [31:0]      mem_node_o,
    output logic             mem_x_c_o,
    output logic             mem_c_c_o,
    output logic             mem_w_c_o,
    output logic             mem_t_c_o,
    output logic             mem_m_c_o,
    output logic             mem_rd_wr_o,
    input  logic [31:0]      mem_class_i,
    input  logic [31:0]      mem_th_i,
    input  logic [31:0]      mem_m_i,
    input  logic [VEC_W-1:0] mem_w_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [31:0]      rec_class_o,
    output logic [31:0]      rec_node_o,
    output logic [31:0]      rec_th_o,
    output logic [31:0]      rec_m_o,
    output logic [VEC_W-1:0] rec_w_o,
    output logic             rec_last_o
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

    localparam logic [31:0] LAST_NODE  = 32'(NODES_PER_CLASS - 1);
    localparam logic [31:0] LAST_CLASS = 32'(NUM_CLASSES - 1);

    state_t      state, state_nxt;
    logic [31:0] cur_class, cur_node, end_class;
    logic        is_last, sel_bad, skip_node;
    logic        start_ok, advance, err_nxt;

    assign is_last = (cur_node == LAST_NODE) && (cur_class == end_class);
    // Unsigned compare also rejects negative ints (they look huge).
    assign sel_bad = !all_classes_i && (class_sel_i > LAST_CLASS);

`ifdef GAM_SCAN_SKIP_EMPTY_EN
    assign skip_node = (mem_m_i == 32'd0);
`else
    assign skip_node = 1'b0;
`endif

    // Memory interface is pure decode of state: strobes only in READ, never a write.
    assign mem_class_o = (state == S_READ) ? cur_class : 32'd0;
    assign mem_node_o  = (state == S_READ) ? cur_node  : 32'd0;
    assign mem_c_c_o   = (state == S_READ);
    assign mem_w_c_o   = (state == S_READ);
    assign mem_t_c_o   = (state == S_READ);
    assign mem_m_c_o   = (state == S_READ);
    assign mem_x_c_o   = 1'b0;
    assign mem_rd_wr_o = 1'b0;
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE);
    assign rec_valid_o = (state == S_HOLD);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and index-control decode.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        advance   = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (sel_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        start_ok  = 1'b1;
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                if (skip_node) begin
                    // Empty node: move on without presenting it.
                    if (is_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_READ;
                    end
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rec_ready_i) begin
                    if (is_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_READ;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Class/node walk counters; node wraps into the next class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_class <= 32'd0;
            cur_node  <= 32'd0;
            end_class <= 32'd0;
        end else if (start_ok) begin
            cur_class <= all_classes_i ? 32'd0 : class_sel_i;
            end_class <= all_classes_i ? LAST_CLASS : class_sel_i;
            cur_node  <= 32'd0;
        end else if (advance) begin
            if (cur_node == LAST_NODE) begin
                cur_node  <= 32'd0;
                cur_class <= cur_class + 32'd1;
            end else begin
                cur_node  <= cur_node + 32'd1;
            end
        end
    end

    // Record capture from the combinational memory at the end of READ; frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_class_o <= 32'd0;
            rec_node_o  <= 32'd0;
            rec_th_o    <= 32'd0;
            rec_m_o     <= 32'd0;
            rec_w_o     <= '0;
            rec_last_o  <= 1'b0;
        end else if (state == S_READ) begin
            rec_class_o <= mem_class_i;
            rec_node_o  <= cur_node;
            rec_th_o    <= mem_th_i;
            rec_m_o     <= mem_m_i;
            rec_w_o     <= mem_w_i;
            rec_last_o  <= is_last && !skip_node;
        end
    end

    // Out-of-range class request reported one cycle after start_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_o <= 1'b0;
        else        err_o <= err_nxt;
    end

endmodule

// File: tb/tb_gam_node_scanner.sv
module tb_gam_node_scanner;

    localparam int NC = 8;
    localparam int NP = 16;
    localparam int VW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          all_classes_i = 1'b0;
    logic [31:0]   class_sel_i = 32'd0;
    logic          busy_o, done_o, err_o;
    logic [31:0]   mem_class_o, mem_node_o;
    logic          mem_x_c_o, mem_c_c_o, mem_w_c_o, mem_t_c_o, mem_m_c_o, mem_rd_wr_o;
    logic [31:0]   mem_class_i, mem_th_i, mem_m_i;
    logic [VW-1:0] mem_w_i;
    logic          rec_valid_o;
    logic          rec_ready_i = 1'b1;
    logic [31:0]   rec_class_o, rec_node_o, rec_th_o, rec_m_o;
    logic [VW-1:0] rec_w_o;
    logic          rec_last_o;

    gam_node_scanner #(.NUM_CLASSES(NC), .NODES_PER_CLASS(NP), .VEC_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .all_classes_i(all_classes_i),
        .class_sel_i(class_sel_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_class_o(mem_class_o), .mem_node_o(mem_node_o), .mem_x_c_o(mem_x_c_o),
        .mem_c_c_o(mem_c_c_o), .mem_w_c_o(mem_w_c_o), .mem_t_c_o(mem_t_c_o),
        .mem_m_c_o(mem_m_c_o), .mem_rd_wr_o(mem_rd_wr_o), .mem_class_i(mem_class_i),
        .mem_th_i(mem_th_i), .mem_m_i(mem_m_i), .mem_w_i(mem_w_i),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_class_o(rec_class_o),
        .rec_node_o(rec_node_o), .rec_th_o(rec_th_o), .rec_m_o(rec_m_o),
        .rec_w_o(rec_w_o), .rec_last_o(rec_last_o)
    );

    always #5 clk = ~clk;

    // Memory contents model.
    function automatic logic [31:0] f_name(input logic [31:0] c);
        return 32'hC1A5_0000 | c;
    endfunction
    function automatic logic [31:0] f_th(input logic [31:0] c, input logic [31:0] n);
        return c * 32'd1000 + n;
    endfunction
    function automatic logic [31:0] f_m(input logic [31:0] c, input logic [31:0] n);
        if (c == 32'd2 && (n == 32'd1 || n == 32'd5 || n == 32'd15)) return 32'd0;
        return c * 32'd16 + n + 32'd1;
    endfunction
    function automatic logic [VW-1:0] f_w(input logic [31:0] c, input logic [31:0] n);
        return {8{(c * 32'h9E37_79B9) ^ n}};
    endfunction

    assign mem_class_i = f_name(mem_class_o);
    assign mem_th_i    = f_th(mem_class_o, mem_node_o);
    assign mem_m_i     = f_m(mem_class_o, mem_node_o);
    assign mem_w_i     = f_w(mem_class_o, mem_node_o);

    typedef struct {
        logic [31:0]   cls;
        logic [31:0]   node;
        logic [31:0]   th;
        logic [31:0]   m;
        logic [VW-1:0] w;
        logic          last;
    } rec_t;

    rec_t exp_q[$];
    rec_t e, held;
    bit   stall_prev = 1'b0;
    int   checks = 0, errors = 0;
    int   done_cnt = 0, err_cnt = 0, rec_cnt = 0;
`ifdef GAM_SCAN_SKIP_EMPTY_EN
    bit   skip_en = 1'b1;
`else
    bit   skip_en = 1'b0;
`endif

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the records a scan must produce, in order.
    task automatic push_scan(input bit all, input int sel);
        int c0, c1;
        rec_t r;
        c0 = all ? 0 : sel;
        c1 = all ? NC - 1 : sel;
        for (int c = c0; c <= c1; c++) begin
            for (int n = 0; n < NP; n++) begin
                if (skip_en && f_m(32'(c), 32'(n)) == 32'd0) continue;
                r.cls  = f_name(32'(c));
                r.node = 32'(n);
                r.th   = f_th(32'(c), 32'(n));
                r.m    = f_m(32'(c), 32'(n));
                r.w    = f_w(32'(c), 32'(n));
                r.last = (c == c1) && (n == NP - 1);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic pulse_start(input bit all, input int sel);
        all_classes_i = all;
        class_sel_i   = 32'(sel);
        start_i       = 1'b1;
        tick();
        start_i       = 1'b0;
    endtask

    // Wait, bounded, for the done counter to move past d0.
    task automatic wait_done(input int d0, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick();
            if (done_cnt != d0) got = 1'b1;
        end
        chk(name, got, 1'b1);
    endtask

    // Wait, bounded, for a presented record with the given node index.
    task automatic wait_node(input int node, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rec_valid_o && rec_node_o == 32'(node)) got = 1'b1;
            else if (rec_valid_o) begin
                rec_ready_i = 1'b1;
                tick();
                rec_ready_i = 1'b0;
            end else tick();
        end
        chk(name, got, 1'b1);
    endtask

    // Scoreboard and protocol monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_wr_read", mem_rd_wr_o, 1'b0);
            chk("x_strobe", mem_x_c_o, 1'b0);
            if (!busy_o || rec_valid_o)
                chk("idle_strobes", {mem_c_c_o, mem_w_c_o, mem_t_c_o, mem_m_c_o}, 4'd0);
            if (stall_prev) begin
                chk("hold_fields", {rec_valid_o, rec_class_o, rec_node_o, rec_th_o, rec_m_o, rec_last_o},
                    {1'b1, held.cls, held.node, held.th, held.m, held.last});
                chk("hold_w", rec_w_o, held.w);
            end
            stall_prev = rec_valid_o && !rec_ready_i;
            held.cls = rec_class_o; held.node = rec_node_o; held.th = rec_th_o;
            held.m = rec_m_o; held.w = rec_w_o; held.last = rec_last_o;
            if (rec_valid_o && rec_ready_i) begin
                rec_cnt++;
                chk("rec_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rec_class", rec_class_o, e.cls);
                    chk("rec_node", rec_node_o, e.node);
                    chk("rec_th", rec_th_o, e.th);
                    chk("rec_m", rec_m_o, e.m);
                    chk("rec_w", rec_w_o, e.w);
                    chk("rec_last", rec_last_o, e.last);
                end
            end
            if (done_o) done_cnt++;
            if (err_o)  err_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    typedef struct {
        bit all;
        int sel;
        bit err;
        int n_rec;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d0, e0, r0, k, kv;

        vecs[0] = '{1'b0, 3, 1'b0, 16};
        vecs[1] = '{1'b0, 0, 1'b0, 16};
        vecs[2] = '{1'b0, 7, 1'b0, 16};
        vecs[3] = '{1'b0, 9, 1'b1, 0};
        vecs[4] = '{1'b0, -1, 1'b1, 0};
        vecs[5] = '{1'b1, 5, 1'b0, 128};
        vecs[6] = '{1'b0, 2, 1'b0, skip_en ? 13 : 16};

        // Reset state.
        #12;
        chk("rst_ctrl", {busy_o, done_o, err_o, rec_valid_o, rec_last_o, mem_c_c_o, mem_w_c_o,
                         mem_t_c_o, mem_m_c_o, mem_x_c_o, mem_rd_wr_o}, 11'd0);
        chk("rst_idx", {mem_class_o, mem_node_o}, 64'd0);
        chk("rst_rec", {rec_class_o, rec_node_o, rec_th_o, rec_m_o}, 128'd0);
        chk("rst_w", rec_w_o, 256'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven scans, ready held high.
        for (int v = 0; v < 7; v++) begin
            if (!vecs[v].err) push_scan(vecs[v].all, vecs[v].sel);
            d0 = done_cnt; e0 = err_cnt; r0 = rec_cnt;
            pulse_start(vecs[v].all, vecs[v].sel);
            if (vecs[v].err) begin
                for (int i = 0; i < 4; i++) begin
                    chk("err_busy", {busy_o, mem_c_c_o}, 2'b00);
                    tick();
                end
            end else begin
                wait_done(d0, "scan_done_seen");
            end
            tick(); tick();
            chk("done_count", done_cnt - d0, vecs[v].err ? 0 : 1);
            chk("err_count", err_cnt - e0, vecs[v].err ? 1 : 0);
            chk("rec_count", rec_cnt - r0, vecs[v].n_rec);
            chk("queue_empty", exp_q.size(), 0);
        end

        // Latency: READ right after start, first valid one cycle later, done 32 cycles after READ.
        push_scan(1'b0, 3);
        d0 = done_cnt;
        pulse_start(1'b0, 3);
        chk("read_strobes", {mem_c_c_o, mem_w_c_o, mem_t_c_o, mem_m_c_o, rec_valid_o}, 5'b11110);
        chk("read_index", {mem_class_o, mem_node_o}, {32'd3, 32'd0});
        k = 0; kv = -1;
        while (!done_o && k < 100) begin
            tick();
            k++;
            if (rec_valid_o && kv < 0) kv = k;
        end
        chk("first_valid_lat", kv, 1);
        chk("done_lat", k, 32);
        tick();
        chk("idle_after_done", busy_o, 1'b0);
        tick();
        chk("done_once", done_cnt - d0, 1);

        // Start mid-scan is ignored.
        push_scan(1'b0, 0);
        d0 = done_cnt; r0 = rec_cnt;
        pulse_start(1'b0, 0);
        repeat (7) tick();
        pulse_start(1'b1, 5);
        wait_done(d0, "midstart_done_seen");
        tick(); tick();
        chk("midstart_recs", rec_cnt - r0, 16);
        chk("midstart_done", done_cnt - d0, 1);

        // Backpressure: stall 5 cycles on node 4.
        push_scan(1'b0, 3);
        d0 = done_cnt;
        rec_ready_i = 1'b0;
        pulse_start(1'b0, 3);
        wait_node(4, "bp_reach_node4");
        repeat (5) begin
            tick();
            chk("bp_stall", {rec_valid_o, mem_c_c_o, rec_node_o}, {1'b1, 1'b0, 32'd4});
        end
        wait_node(5, "bp_node5_follows");
        rec_ready_i = 1'b1;
        wait_done(d0, "bp_done_seen");
        tick(); tick();
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset during HOLD of node 7.
        push_scan(1'b0, 1);
        d0 = done_cnt;
        rec_ready_i = 1'b0;
        pulse_start(1'b0, 1);
        wait_node(7, "rst_reach_node7");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {busy_o, done_o, err_o, rec_valid_o, rec_last_o, mem_c_c_o, mem_w_c_o,
                            mem_t_c_o, mem_m_c_o}, 9'd0);
        chk("midrst_idx", {mem_class_o, mem_node_o}, 64'd0);
        chk("midrst_rec", {rec_class_o, rec_node_o, rec_th_o, rec_m_o, rec_w_o[31:0]}, 160'd0);
        exp_q.delete();
        rec_ready_i = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", done_cnt - d0, 0);
        push_scan(1'b0, 1);
        r0 = rec_cnt;
        pulse_start(1'b0, 1);
        wait_done(d0, "rescan_done_seen");
        tick(); tick();
        chk("rescan_recs", rec_cnt - r0, 16);
        chk("rescan_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gam_node_scanner.md
Name: gam_node_scanner

Overview:
- Read-side initiator for the GAM per-class/per-node memory.
- Walks every node of one class, or of all classes, issuing read strobes with RD_WR = READ.
- Captures class name, threshold, match count and weight vector for each node.
- Streams each node out as a record on a valid/ready interface for the classification/learning layers.
- Never issues writes.

Parameters:
NUM_CLASSES, 8, number of classes in memory
NODES_PER_CLASS, 16, nodes per class
VEC_W, 256, bit width of node_vector_T

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  single-cycle scan request
all_classes_i  in  1  1: scan classes 0..NUM_CLASSES-1; 0: scan class_sel_i only
class_sel_i  in  32  class to scan (int)
busy_o  out  1  scan in progress
done_o  out  1  one-cycle pulse at scan end
err_o  out  1  one-cycle pulse, class_sel_i out of range
mem_class_o  out  32  class index to memory
mem_node_o  out  32  node index to memory
mem_x_c_o  out  1  X field strobe, always 0
mem_c_c_o  out  1  class-name strobe
mem_w_c_o  out  1  weight strobe
mem_t_c_o  out  1  threshold strobe
mem_m_c_o  out  1  match-count strobe
mem_rd_wr_o  out  1  RD_WR_T encoding, 0 = READ, constant READ
mem_class_i  in  32  class name from memory
mem_th_i  in  32  threshold from memory
mem_m_i  in  32  match count from memory
mem_w_i  in  VEC_W  weight vector from memory
rec_valid_o  out  1  record valid
rec_ready_i  in  1  downstream ready
rec_class_o  out  32  captured class name
rec_node_o  out  32  node index of record
rec_th_o  out  32  captured threshold
rec_m_o  out  32  captured match count
rec_w_o  out  VEC_W  captured weight vector
rec_last_o  out  1  record is the final index of the scan

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. All outputs 0, including indices, strobes, record fields and pulses. Reset mid-scan abandons the scan silently; no done_o.
- FSM states:
  - IDLE: waits for start_i.
    - If all_classes_i = 0 and class_sel_i is outside 0..NUM_CLASSES-1: err_o pulses the next cycle and FSM stays IDLE.
    - Otherwise: latch start class (0 or class_sel_i), node = 0, go READ.
  - READ (one cycle):
    - Drive mem_class_o/mem_node_o; assert C/W/T/M strobes; X strobe 0; RD_WR = READ.
    - The memory is combinational. At the clock edge, capture mem_*_i into the rec_* registers.
    - rec_last_o = 1 when node = NODES_PER_CLASS-1 and class is the final class of the scan.
    - Go HOLD.
  - HOLD: rec_valid_o = 1; record fields stable. On rec_valid_o & rec_ready_i:
    - If last: go DONE.
    - Else: node+1, wrapping to 0 with class+1. Go READ.
  - DONE: done_o = 1 for one cycle, then IDLE.
- busy_o = 1 in READ, HOLD and DONE.
- Strobes are 0 in all states except READ, so the memory sees no write.
- Throughput: 1 record per 2 cycles when rec_ready_i is held high.
- Latency: first rec_valid_o 2 cycles after start_i.
- Backpressure: HOLD may persist indefinitely. Fields must not change while valid && !ready.
- start_i while busy_o = 1 is ignored.
- Index counters are 32-bit ints. Comparisons are against parameter-1; no overflow is possible.

Optional Feature:
- Macro: GAM_SCAN_SKIP_EMPTY_EN.
- Defined:
  - After READ, a node with captured mem_m_i == 0 is not presented: rec_valid_o stays 0 and the FSM advances as if accepted. Cost is 1 cycle per skipped node.
  - If a skipped node is the final index, go directly to DONE. No record carries rec_last_o in that scan; done_o is authoritative.
- Undefined: every node is emitted regardless of match count.

Test Plan:
- Single class: all_classes_i = 0, class_sel_i = 3, rec_ready_i = 1.
  - Expect 16 records, rec_node_o 0..15, rec_class_o equal to the memory's class-3 name.
  - rec_last_o only on node 15; done_o 32 cycles after the first READ; mem_rd_wr_o = READ throughout.
- All classes: all_classes_i = 1.
  - Expect 128 records, class wrap after node 15.
  - rec_last_o on (class 7, node 15); done_o exactly once.
- Backpressure: rec_ready_i low for 5 cycles on the node-4 record.
  - Fields held unchanged; no READ strobes during the stall; node 5 follows once ready.
- Error/ignore cases:
  - class_sel_i = 9 with all_classes_i = 0: err_o pulses once, busy_o stays 0, no strobes.
  - start_i pulsed mid-scan: ignored.
- Reset mid-scan: assert rst_n = 0 during HOLD of node 7.
  - All outputs 0 immediately; no done_o.
  - A new start_i then scans again from node 0.
- GAM_SCAN_SKIP_EMPTY_EN with class 2 match counts 0 at nodes 1, 5 and 15:
  - 13 records emitted; none has rec_last_o; done_o is still asserted.
